mac_operand_feeder: RTL
=======================

# mac_operand_feeder

Operand source and sequencer on the far side of the MAC control interface. The block buffers up to DEPTH (a, b) operand pairs written by the host. On a host start it issues a single `go` pulse to the MAC control path. It then presents one pair per `count_enable` strobe and raises `cmp` once the last pair has been consumed. When the control path asserts `load_out`, the block reports completion to the host and returns to idle.

## Interface
Parameters:
- DATA_W, 8, width of each operand
- DEPTH, 16, operand buffer depth (power of two)
- ADDR_W, 4, log2(DEPTH)

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  host write strobe for the operand buffer
- wr_addr  in  ADDR_W  buffer write address
- wr_a  in  DATA_W  operand a to store
- wr_b  in  DATA_W  operand b to store
- start  in  1  host request to run a dot product
- len  in  ADDR_W+1  number of pairs, 1..DEPTH, sampled with start
- count_enable  in  1  from control path: current pair is being loaded, advance
- load_out  in  1  from control path: result is being registered
- go  out  1  to control path: one-cycle run request
- cmp  out  1  to control path: all len pairs have been consumed
- a_out  out  DATA_W  operand a presented to the datapath
- b_out  out  DATA_W  operand b presented to the datapath
- busy  out  1  run in progress
- done  out  1  one-cycle pulse when the run completes
- err  out  1  one-cycle pulse when a command is rejected

## Operation
- Buffer: DEPTH x 2·DATA_W registers, no reset.
  - Write on wr_en only while busy=0.
  - wr_en while busy=1: write dropped, err pulses.
- Internal registers: idx (ADDR_W+1 bits), len_q (ADDR_W+1 bits).
- State machine IDLE, ARM, ISSUE, RUN, FIN:
  - IDLE:
    - start with 1 ≤ len ≤ DEPTH: len_q←len, idx←0, cmp←0, go to ARM.
    - start with len=0 or len>DEPTH: err pulses, stay in IDLE.
  - ARM: a_out/b_out←buf[0]. Go to ISSUE.
  - ISSUE: go=1 for exactly this cycle. Go to RUN.
  - RUN: on each count_enable, idx←idx+1. On load_out, go to FIN.
  - FIN: done=1 for one cycle, busy drops. Go to IDLE.
- Operand registers: a_out/b_out←buf[idx[ADDR_W-1:0]] on every clock while busy=1, so they track idx one cycle later.
  - Operands are stable whenever the control path strobes count_enable, because strobes are at least 6 cycles apart.
- cmp is registered: cmp←(idx+1 == len_q) on the count_enable edge. It holds at 1 until the next accepted start.
- Ignored inputs:
  - count_enable when idx == len_q: idx saturates.
  - count_enable or load_out outside RUN.
  - start while busy=1: no effect, err pulses.
- Simultaneous start and wr_en in IDLE: the write completes and start is accepted. A write to address 0 in that cycle is visible in ARM.
- busy=1 in ARM, ISSUE and RUN. busy falls to 0 on the FIN→IDLE edge.

## Timing
- Reset values: go=0, cmp=0, a_out=0, b_out=0, busy=0, done=0, err=0; state=IDLE, idx=0, len_q=0.
- Reset mid-run: all of the above apply immediately. Buffer contents are retained.
- Cycle numbering, with the start sampled at edge 0:
  - ARM during cycle 1.
  - go high during cycle 2; a_out=buf[0] is already valid in cycle 2.
  - Control path S1 occurs during cycle 3. The count_enable edge at the end of cycle 3 sets idx=1.
  - a_out=buf[1] from cycle 5, well before the next S1 at cycle 9.
- Per pair the control path spends 6 cycles (S1..S6). cmp must be valid at S6 of pair len-1; it is valid 1 cycle after that pair's count_enable.
- Latency from start to done ≈ 3 + 6·len + 2 cycles. done follows the load_out cycle by 1.
- err and done are single-cycle pulses and never asserted together.

## Test plan
- Reset check: apply rst mid-stream, then sample all outputs. Required: all outputs 0, state IDLE.
- Single pair: write buf[0]=(3,5), start with len=1, drive a control-path model.
  - Required: go pulses once at cycle 2, a_out=3/b_out=5 at S1, cmp=1 by S6, done one cycle after load_out, accumulated result 15.
- Four pairs (1,2),(3,4),(5,6),(7,8), len=4.
  - Required: a_out/b_out sequence matches the buffer order.
  - Required: cmp stays 0 until after the 4th count_enable, exactly 4 count_enable strobes occur, final result 100.
- Full depth: len=16 with all pairs (1,1). Required: idx reaches 16, cmp=1, result 16, no wrap to buf[0].
- Rejections:
  - start with len=0: err pulse, go stays 0.
  - wr_en during RUN: err pulse, buffer unchanged afterward.
  - start during RUN: err pulse, run unaffected.
- Reset mid-run after 2 of 4 pairs.
  - Required: busy=0 and cmp=0 immediately.
  - Required: a new start with len=4 reruns from buf[0] and produces the correct result.

Source files
------------

// File: rtl/mac_operand_feeder.sv
// rtl/mac_operand_feeder.sv - operand buffer and run sequencer for the MAC control path
module mac_operand_feeder #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_a,
    input  logic [DATA_W-1:0] wr_b,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              count_enable,
    input  logic              load_out,
    output logic              go,
    output logic              cmp,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_ISSUE,
        S_RUN,
        S_FIN
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t state, state_nx;

    logic [2*DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]     idx;
    logic [ADDR_W:0]     len_q;
    logic                len_ok;
    logic                start_ok;
    logic                ce_ok;
    logic                err_req;
    logic                err_pend;

    assign busy     = (state != S_IDLE);
    assign go       = (state == S_ISSUE);
    assign done     = (state == S_FIN);
    assign len_ok   = (len != '0) && (len <= DEPTH_L);
    assign start_ok = (state == S_IDLE) && start && len_ok;
    assign ce_ok    = (state == S_RUN) && count_enable && (idx < len_q);
    assign err_req  = (wr_en && busy) || (start && (busy || !len_ok));

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start_ok) state_nx = S_ARM;
            S_ARM:   state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_RUN;
            S_RUN:   if (load_out) state_nx = S_FIN;
            S_FIN:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand storage is deliberately left out of reset so a reset mid-run keeps the host's data.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem[wr_addr] <= {wr_a, wr_b};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            len_q    <= '0;
            cmp      <= 1'b0;
            a_out    <= '0;
            b_out    <= '0;
            err      <= 1'b0;
            err_pend <= 1'b0;
        end else begin
            state <= state_nx;

            if (start_ok) begin
                len_q <= len;
                idx   <= '0;
                cmp   <= 1'b0;
            end else if (ce_ok) begin
                idx <= idx + (ADDR_W+1)'(1);
                cmp <= ((idx + (ADDR_W+1)'(1)) == len_q);
            end

            // Past the last pair the index equals len_q; holding the operands avoids showing buf[0] again.
            if (busy && (idx < len_q)) begin
                {a_out, b_out} <= mem[idx[ADDR_W-1:0]];
            end

            // A rejection landing on the cycle that enters FIN is deferred so err never overlaps done.
            if (state == S_RUN && load_out) begin
                err      <= 1'b0;
                err_pend <= err_req;
            end else begin
                err      <= err_req || err_pend;
                err_pend <= 1'b0;
            end
        end
    end

endmodule
